// File: rtl/regfile_wq_pkg.sv
// regfile_wq_pkg: shared sizes and entry type for the register file write queue
package regfile_wq_pkg;
  localparam int DTYPE_W = 8;
  localparam int NREGS   = 4;
  localparam int DEPTH   = 4;
  localparam int AW      = $clog2(NREGS);
  localparam int PTR_W   = $clog2(DEPTH);
  typedef struct packed {
    logic [AW-1:0]      addr;
    logic [DTYPE_W-1:0] data;
  } wq_entry_t;
endpackage

// File: rtl/regfile_wq_match.sv
// regfile_wq_match: pending mask and youngest-match forwarding over valid queue entries
module regfile_wq_match
  import regfile_wq_pkg::*;
(
  input  wq_entry_t          entries [DEPTH],
  input  logic [PTR_W-1:0]   head,
  input  logic [PTR_W:0]     count,
  input  logic [AW-1:0]      lookup_addr,
  output logic [NREGS-1:0]   pending,
  output logic               lookup_hit,
  output logic [DTYPE_W-1:0] lookup_data
);
  // walk oldest to youngest so a later match overwrites an earlier one
  always_comb begin
    pending     = '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PTR_W+1)'(i) < count) begin
        pending[entries[head + PTR_W'(i)].addr] = 1'b1;
        if (entries[head + PTR_W'(i)].addr == lookup_addr) begin
          lookup_hit  = 1'b1;
          lookup_data = entries[head + PTR_W'(i)].data;
        end
      end
    end
  end
endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order writeback buffer draining into a single register file write port
module regfile_write_queue
  import regfile_wq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [AW-1:0]      enq_addr,
  input  logic [DTYPE_W-1:0] enq_data,
  input  logic               drain_en,
  output logic               wr_call,
  output logic [AW-1:0]      wr_addr,
  output logic [DTYPE_W-1:0] wr_data,
  output logic [NREGS-1:0]   pending,
  input  logic [AW-1:0]      lookup_addr,
  output logic               lookup_hit,
  output logic [DTYPE_W-1:0] lookup_data
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  wq_entry_t          mem_q [DEPTH];
  wq_entry_t          mem_d [DEPTH];
  logic               enq_fire, not_empty, m_hit;
  logic [NREGS-1:0]   m_pending;
  logic [DTYPE_W-1:0] m_data;
  assign not_empty   = count_q != '0;
  assign enq_rdy     = !reset && count_q != FULL;
  assign enq_fire    = enq_val && enq_rdy;
  assign wr_call     = !reset && not_empty && drain_en;
  assign wr_addr     = not_empty ? mem_q[head_q].addr : '0;
  assign wr_data     = not_empty ? mem_q[head_q].data : '0;
  assign pending     = reset ? '0 : m_pending;
  assign lookup_hit  = !reset && m_hit;
  assign lookup_data = reset ? '0 : m_data;
  regfile_wq_match u_match (
    .entries    (mem_q),
    .head       (head_q),
    .count      (count_q),
    .lookup_addr(lookup_addr),
    .pending    (m_pending),
    .lookup_hit (m_hit),
    .lookup_data(m_data)
  );
  // next pointers, count and storage; a full queue refuses enqueue even while draining
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q + PTR_W'(wr_call);
    tail_d  = tail_q + PTR_W'(enq_fire);
    count_d = count_q + (PTR_W+1)'(enq_fire) - (PTR_W+1)'(wr_call);
    if (enq_fire) mem_d[tail_q] = '{addr: enq_addr, data: enq_data};
  end
  // state registers; entry contents need no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed scoreboard bench for the register file write queue
module tb_regfile_write_queue;
  logic       clk = 0, reset = 1, enq_val = 0, drain_en = 0;
  logic       enq_rdy, wr_call, lookup_hit;
  logic [1:0] enq_addr = 0, wr_addr, lookup_addr = 0;
  logic [7:0] enq_data = 0, wr_data, lookup_data;
  logic [3:0] pending;
  int         checks = 0, failures = 0;
  int         sb[$];

  regfile_write_queue dut (
    .clk(clk), .reset(reset), .enq_val(enq_val), .enq_rdy(enq_rdy),
    .enq_addr(enq_addr), .enq_data(enq_data), .drain_en(drain_en),
    .wr_call(wr_call), .wr_addr(wr_addr), .wr_data(wr_data),
    .pending(pending), .lookup_addr(lookup_addr),
    .lookup_hit(lookup_hit), .lookup_data(lookup_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every register file write must be the oldest outstanding expected write
  always @(negedge clk) begin
    if (!reset && wr_call) begin
      if (sb.size() == 0) chk("unexpected_write", {22'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      else chk("write_order", {22'd0, wr_addr, wr_data}, sb.pop_front());
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [1:0] a, input logic [7:0] d, input logic acc);
    enq_val  = 1;
    enq_addr = a;
    enq_data = d;
    @(negedge clk);
    chk("enq_rdy_at_enq", int'(enq_rdy), int'(acc));
    if (acc) sb.push_back({22'd0, a, d});
    cyc();
    enq_val = 0;
  endtask

  task automatic drain_all;
    drain_en = 1;
    repeat (6) cyc();
  endtask

  initial begin
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_enq_rdy", int'(enq_rdy), 0);
    chk("rst_wr_call", int'(wr_call), 0);
    chk("rst_pending", int'(pending), 0);
    cyc();
    reset = 0;
    @(negedge clk);
    chk("post_rst_enq_rdy", int'(enq_rdy), 1);
    chk("post_rst_wr_call", int'(wr_call), 0);
    cyc();
    // 1: single write, no bypass, visible next cycle
    drain_en = 1;
    enq(2, 8'hA5, 1);
    @(negedge clk);
    chk("t1_wr_call", int'(wr_call), 1);
    chk("t1_pending", int'(pending), 4'b0100);
    cyc();
    @(negedge clk);
    chk("t1_wr_call_after", int'(wr_call), 0);
    chk("t1_pending_after", int'(pending), 0);
    cyc();
    // 2: fill, reject fifth, then drain in order
    drain_en = 0;
    for (int i = 0; i < 4; i++) enq(2'(i), 8'h10 + 8'(i), 1);
    enq(0, 8'hFF, 0);
    @(negedge clk);
    chk("t2_pending_full", int'(pending), 4'b1111);
    drain_en = 1;
    cyc();
    @(negedge clk);
    chk("t2_enq_rdy_after_drain", int'(enq_rdy), 1);
    drain_all();
    chk("t2_empty", sb.size(), 0);
    // 3: youngest-match forwarding
    drain_en = 0;
    enq(1, 8'h11, 1);
    enq(1, 8'h22, 1);
    lookup_addr = 1;
    @(negedge clk);
    chk("t3_hit", int'(lookup_hit), 1);
    chk("t3_data", int'(lookup_data), 8'h22);
    chk("t3_pending", int'(pending), 4'b0010);
    lookup_addr = 3;
    @(negedge clk);
    chk("t3_miss_hit", int'(lookup_hit), 0);
    chk("t3_miss_data", int'(lookup_data), 0);
    drain_all();
    // 4: full with simultaneous drain and enqueue attempt
    drain_en = 0;
    for (int i = 0; i < 4; i++) enq(2'(i), 8'h40 + 8'(i), 1);
    drain_en = 1;
    enq(3, 8'h99, 0);
    drain_en = 0;
    lookup_addr = 3;
    @(negedge clk);
    chk("t4_enq_rdy", int'(enq_rdy), 1);
    chk("t4_pending_count3", int'(pending), 4'b1110);
    chk("t4_lookup_not_enq", int'(lookup_data), 8'h43);
    drain_all();
    // 5: steady state count 2, pointers wrap twice
    drain_en = 0;
    enq(0, 8'h50, 1);
    enq(1, 8'h51, 1);
    drain_en = 1;
    for (int k = 2; k < 10; k++) enq(2'(k), 8'h50 + 8'(k), 1);
    drain_en = 0;
    lookup_addr = 0;
    @(negedge clk);
    chk("t5_pending", int'(pending), 4'b0011);
    chk("t5_lookup", int'(lookup_data), 8'h58);
    drain_all();
    // 6: reset discards queued entries
    drain_en = 0;
    for (int i = 1; i < 4; i++) enq(2'(i), 8'h60 + 8'(i), 1);
    reset = 1;
    sb.delete();
    lookup_addr = 1;
    cyc();
    reset = 0;
    drain_en = 1;
    @(negedge clk);
    chk("t6_wr_call", int'(wr_call), 0);
    chk("t6_pending", int'(pending), 0);
    chk("t6_hit", int'(lookup_hit), 0);
    chk("t6_enq_rdy", int'(enq_rdy), 1);
    repeat (5) cyc();
    chk("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
